// File: rtl/fpga_rx_com.sv
// Slave-side receiver for the 3-word serial link: rebuilds three MSB-first words
// from a strobe-paced data line, with a strobe-gap timeout so a stalled link cannot hang it.
module fpga_rx_com #(
    parameter int unsigned WORD_W  = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_rx,
    input  logic              sync_rx,
    input  logic              rx,
    output logic [WORD_W-1:0] word1,
    output logic [WORD_W-1:0] word2,
    output logic [WORD_W-1:0] word3,
    output logic              valid_rx,
    output logic              busy_rx,
    output logic              err_rx
);

    localparam int unsigned CNT_W = $clog2(WORD_W) + 1;
    localparam int unsigned GAP_W = 16;

    typedef enum logic [2:0] {IDLE, ARM, RX_1, RX_2, RX_3, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [WORD_W-1:0]  sh1_q, sh1_d;
    logic [WORD_W-1:0]  sh2_q, sh2_d;
    logic [WORD_W-1:0]  sh3_q, sh3_d;
    logic [WORD_W-1:0]  word1_d, word2_d, word3_d;
    logic               valid_d, busy_d, err_d;
    logic               last_bit;
    logic               gap_hit;
    logic               in_rx;

    assign last_bit = (bit_q == CNT_W'(WORD_W - 1));
    assign gap_hit  = (gap_q == GAP_W'(TIMEOUT - 1));
    assign in_rx    = (state_q == ARM) || (state_q == RX_1) ||
                      (state_q == RX_2) || (state_q == RX_3);

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        sh3_d   = sh3_q;
        word1_d = word1;
        word2_d = word2;
        word3_d = word3;
        valid_d = 1'b0;
        err_d   = err_rx;

        case (state_q)
            IDLE: begin
                if (start_rx) begin
                    state_d = ARM;
                    err_d   = 1'b0;
                    gap_d   = '0;
                    bit_d   = '0;
                end
            end
            ARM: begin
                if (sync_rx) begin
                    state_d = RX_1;
                    bit_d   = '0;
                    gap_d   = '0;
                end
            end
            RX_1, RX_2, RX_3: begin
                if (sync_rx) begin
                    gap_d = '0;
                    if (state_q == RX_1)      sh1_d = {sh1_q[WORD_W-2:0], rx};
                    else if (state_q == RX_2) sh2_d = {sh2_q[WORD_W-2:0], rx};
                    else                      sh3_d = {sh3_q[WORD_W-2:0], rx};
                    if (last_bit) begin
                        bit_d = '0;
                        if (state_q == RX_1)      state_d = RX_2;
                        else if (state_q == RX_2) state_d = RX_3;
                        else begin
                            // Final bit goes straight to word3 so words and valid_rx align in DONE
                            state_d = DONE;
                            word1_d = sh1_q;
                            word2_d = sh2_q;
                            word3_d = {sh3_q[WORD_W-2:0], rx};
                            valid_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobe-gap timeout: abort the frame, keep the last good words
        if (in_rx && !sync_rx) begin
            if (gap_hit) begin
                state_d = IDLE;
                err_d   = 1'b1;
                bit_d   = '0;
                gap_d   = '0;
                sh1_d   = '0;
                sh2_d   = '0;
                sh3_d   = '0;
            end else if (gap_q != '1) begin
                gap_d = gap_q + GAP_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            gap_q    <= '0;
            sh1_q    <= '0;
            sh2_q    <= '0;
            sh3_q    <= '0;
            word1    <= '0;
            word2    <= '0;
            word3    <= '0;
            valid_rx <= 1'b0;
            busy_rx  <= 1'b0;
            err_rx   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            sh3_q    <= sh3_d;
            word1    <= word1_d;
            word2    <= word2_d;
            word3    <= word3_d;
            valid_rx <= valid_d;
            busy_rx  <= busy_d;
            err_rx   <= err_d;
        end
    end

endmodule

// File: doc/fpga_rx_com.md
Name: fpga_rx_com

Overview:
- Serial frame receiver; the receiving end of the 3-word serial link on the slave side.
- Rebuilds three 4-bit words from a single data line. Bits are paced by a shared bit strobe, and each word is sent MSB first.
- The remote transmitter holds the line at 0 when idle and launches one bit per strobe. Completed words go to the slave datapath with a one-cycle valid pulse.
- Adds a strobe-gap timeout so a stalled link cannot hang the receiver.

Parameters:
- WORD_W, 4: bits per word; all three words share this width.
- TIMEOUT, 1000: max clk cycles between consecutive sync_rx strobes while receiving before abort; valid range 1..65535.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start_rx  in  1  frame arm request; asserted in the same cycle as the transmitter's frame start.
- sync_rx  in  1  one-clk bit strobe; the same strobe that paces the transmitter.
- rx  in  1  serial data line.
- word1  out  WORD_W  first received word.
- word2  out  WORD_W  second received word.
- word3  out  WORD_W  third received word.
- valid_rx  out  1  one-cycle pulse; word1..3 have just been updated.
- busy_rx  out  1  high from arm until frame completion or abort.
- err_rx  out  1  sticky timeout flag; cleared by the next accepted start_rx or by reset.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; word1/2/3=0; valid_rx=0; busy_rx=0; err_rx=0; all counters=0.
- States: IDLE, ARM, RX_1, RX_2, RX_3, DONE.
- IDLE:
  - start_rx=1 -> ARM, with err_rx<=0 and gap counter<=0.
  - While busy, start_rx is ignored.
- ARM:
  - The first sync_rx after arm is discarded; at that strobe the transmitter launches bit 1.
  - On that strobe -> RX_1, bit counter=0.
- RX_n:
  - On each sync_rx, sample rx into shift register n: {sh[WORD_W-2:0], rx}. The first sample lands as the MSB.
  - The bit counter increments on each sample.
  - After the WORD_W-th sample, the counter goes to 0 and the state advances to RX_n+1 (RX_3 -> DONE) on the same edge.
  - No sample is lost across a word boundary: a strobe on the cycle after the advance is sampled by the new word.
- Sample timing: rx is sampled on the clk edge where sync_rx=1. This captures the value launched at the previous strobe. Total = 1 discarded strobe + 3*WORD_W sampled strobes.
- DONE (one cycle):
  - word1..3 <= shift registers.
  - valid_rx=1 for exactly this cycle.
  - Next state IDLE.
  - Latency: valid_rx is high the cycle after the final sampling edge.
- word1..3 hold their last value at all other times, including after an abort.
- busy_rx = 1 in ARM, RX_1, RX_2, RX_3 and DONE.
- Timeout:
  - In ARM and RX_n, the gap counter increments each cycle without sync_rx and clears on sync_rx.
  - When the count reaches TIMEOUT: err_rx<=1, state -> IDLE, shift registers cleared, no valid_rx.
  - Counter width is 16 bits; it saturates and does not wrap.
- Simultaneous events:
  - start_rx together with sync_rx in IDLE: the strobe is not counted.
  - start_rx in DONE: ignored; a new frame must arm from IDLE.
- Reset during any state aborts silently: no valid_rx, err_rx=0.

Test Plan:
- Basic frame, WORD_W=4:
  - Stimulus: start_rx; strobes every 8 clks; line bits after the discarded strobe are 1010 0101 1100.
  - Required: word1=0xA, word2=0x5, word3=0xC; one valid_rx pulse one cycle after the 13th strobe; busy_rx falls after DONE.
- Back-to-back frames:
  - Stimulus: frame 0xF,0x0,0x9, then start_rx 2 clks after valid_rx with frame 0x1,0x2,0x3.
  - Required: two valid_rx pulses; final outputs 0x1,0x2,0x3.
- Ignore start while busy:
  - Stimulus: pulse start_rx during RX_2.
  - Required: the frame completes unchanged; exactly one valid_rx.
- Timeout:
  - Stimulus: TIMEOUT=20; stop strobes after 6 samples.
  - Required: err_rx=1 after 20 idle clks; state IDLE; word1..3 keep previous values; no valid_rx.
  - Follow-up: a new start_rx clears err_rx, and the next good frame decodes.
- Reset mid-frame:
  - Stimulus: assert reset asynchronously (not aligned to clk) during RX_3.
  - Required: word1..3=0, busy_rx=0, valid_rx=0 immediately; after release, a new frame decodes correctly.
- Strobe on word boundary:
  - Stimulus: sync_rx every clk.
  - Required: all 12 bits captured; words correct (0x3,0x6,0x9 for stream 0011 0110 1001).
